// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets NUM_REQ byte sources share one UART
//   transmitter. A granted byte is handed to the transmitter with a single
//   start pulse. The arbiter then waits for the transmitter to go busy and
//   back idle before it grants again. If busy never rises within
//   BUSY_TIMEOUT cycles, the byte is dropped and a sticky error is raised.
//
//   Ports
//     clk, rst_n      clock, synchronous active-low reset
//     req_valid[i]    requester i has a byte in req_data[8i+7:8i]
//     req_ready[i]    combinational accept strobe (one-hot or zero)
//     uart_tx_start   one-cycle start pulse to the transmitter
//     uart_tx_data    byte being sent; held until the next grant
//     uart_tx_busy    transmitter busy flag
//     grant_id        index of the requester being served
//     active          a granted byte is in flight
//     err_clr         clears timeout_err
//     timeout_err     sticky: transmitter never went busy after a start
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_tx_start,
  output logic [7:0]                 uart_tx_data,
  input  logic                       uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  input  logic                       err_clr,
  output logic                       timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {ARB, LAUNCH, WAIT_BUSY, WAIT_DONE} state_e;

  state_e                     state_q, state_d;
  logic                       start_q, start_d;
  logic [7:0]                 data_q, data_d;
  logic [GW-1:0]              grant_q, grant_d;
  logic [GW-1:0]              last_q, last_d;
  logic                       active_q, active_d;
  logic                       err_q, err_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [NUM_REQ-1:0]         ready_d;

  logic [NUM_REQ-1:0][7:0]    data_arr;
  logic                       found;
  logic [GW-1:0]              win, idx;

  assign data_arr = req_data;

  // Round-robin search starting just after the last grant, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    data_d   = data_q;
    grant_d  = grant_q;
    last_d   = last_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = err_clr ? 1'b0 : err_q;
    ready_d  = '0;
    unique case (state_q)
      ARB: begin
        if (!uart_tx_busy && found) begin
          ready_d[win] = 1'b1;
          data_d       = data_arr[win];
          grant_d      = win;
          last_d       = win;
          active_d     = 1'b1;
          start_d      = 1'b1;   // registered, so the pulse lands in LAUNCH
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // Byte is dropped; last_q already points past this requester.
          err_d    = 1'b1;       // set wins over err_clr
          active_d = 1'b0;
          state_d  = ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          active_d = 1'b0;
          state_d  = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB;
      start_q  <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
      last_q   <= GW'(NUM_REQ - 1);
      active_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      active_q <= active_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready     = rst_n ? ready_d : '0;
  assign uart_tx_start = start_q;
  assign uart_tx_data  = data_q;
  assign grant_id      = grant_q;
  assign active        = active_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_clr;
  logic        timeout_err;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int bcnt   = 0;
  bit auto_busy = 1'b0;
  int grant_log[$];

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_tx_start(uart_tx_start),
    .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .grant_id(grant_id), .active(active), .err_clr(err_clr),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Round-robin reference: first valid index after 'last', wrapping.
  function automatic int rr_pick(input int last, input logic [3:0] v);
    int i;
    for (int k = 1; k <= 4; k++) begin
      i = (last + k) % 4;
      if (v[i[1:0]]) return i;
    end
    return -1;
  endfunction

  // Advance to just after the next rising edge. The UART model goes busy
  // for 3 cycles starting the cycle after it sees a start pulse.
  task automatic cycle_start();
    bit prev_start;
    prev_start = uart_tx_start;
    @(posedge clk); #1;
    cyc++;
    if (auto_busy) begin
      if (prev_start) bcnt = 3;
      uart_tx_busy = (bcnt > 0);
      if (bcnt > 0) bcnt--;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; err_clr = 1'b0;
    uart_tx_busy = 1'b0; auto_busy = 1'b0; bcnt = 0;
    repeat (3) cycle_start();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Cycle-level traffic against a transaction model: a grant at cycle g
  // gives start at g+1, busy g+2..g+4, active g+1..g+5, next grant >= g+6.
  task automatic run_traffic(input bit all_valid, input int ncyc);
    int gcyc, free, w, last, eg;
    logic [3:0] v, er;
    logic [7:0] ed;
    gcyc = -100; free = 0; last = 3; eg = 0; ed = '0;
    auto_busy = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      cycle_start();
      v = all_valid ? 4'hF : 4'($urandom);
      req_valid = v;
      req_data  = $urandom;
      #3;
      er = '0; w = -1;
      if (cyc >= free && v != 0) begin
        w  = rr_pick(last, v);
        er = 4'(1 << w);
      end
      checks++;
      if (req_ready !== er) begin
        fails++; $display("FAIL traffic_ready cyc=%0d got %b exp %b", cyc, req_ready, er);
      end
      checks++;
      if (active !== (cyc > gcyc && cyc < free)) begin
        fails++; $display("FAIL traffic_active cyc=%0d got %b", cyc, active);
      end
      checks++;
      if (uart_tx_start !== (cyc == gcyc + 1)) begin
        fails++; $display("FAIL traffic_start cyc=%0d got %b", cyc, uart_tx_start);
      end
      if (cyc == gcyc + 1) begin
        checks++;
        if (uart_tx_data !== ed) begin
          fails++; $display("FAIL traffic_data got %h exp %h", uart_tx_data, ed);
        end
        checks++;
        if (grant_id !== 2'(eg)) begin
          fails++; $display("FAIL traffic_gid got %0d exp %0d", grant_id, eg);
        end
      end
      if (w >= 0) begin
        gcyc = cyc; free = cyc + 6; last = w; eg = w;
        ed = req_data[w*8 +: 8];
        grant_log.push_back(w);
      end
    end
    auto_busy = 1'b0;
    uart_tx_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_data = 32'hDEADBEEF;
    err_clr = 1'b0; uart_tx_busy = 1'b0;
    cycle_start(); cycle_start(); #3;
    checks++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    checks++; if (uart_tx_start !== 1'b0) begin fails++; $display("FAIL reset_start got %b exp 0", uart_tx_start); end
    checks++; if (uart_tx_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", uart_tx_data); end
    checks++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_gid got %0d exp 0", grant_id); end
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active got %b exp 0", active); end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", timeout_err); end
  endtask

  task automatic test_single();
    do_reset();
    cycle_start();
    req_valid = 4'b0100; req_data = 32'h11A52233; #3;
    checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    cycle_start();
    req_valid = '0; #3;
    checks++; if (req_ready !== 4'b0) begin fails++; $display("FAIL single_ready2 got %b exp 0", req_ready); end
    checks++; if (uart_tx_start !== 1'b1) begin fails++; $display("FAIL single_start got %b exp 1", uart_tx_start); end
    checks++; if (uart_tx_data !== 8'hA5) begin fails++; $display("FAIL single_data got %h exp a5", uart_tx_data); end
    checks++; if (grant_id !== 2'd2) begin fails++; $display("FAIL single_gid got %0d exp 2", grant_id); end
    checks++; if (active !== 1'b1) begin fails++; $display("FAIL single_active got %b exp 1", active); end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    grant_log.delete();
    run_traffic(1'b1, 30);
    checks++;
    if (grant_log.size() != 5) begin
      fails++; $display("FAIL rr_count got %0d exp 5", grant_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_log[i] != exp_order[i]) begin
          fails++; $display("FAIL rr_order idx=%0d got %0d exp %0d", i, grant_log[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_random_traffic();
    do_reset();
    run_traffic(1'b0, 300);
  endtask

  task automatic test_timeout();
    do_reset();
    cycle_start();
    req_valid = 4'b0001; req_data = $urandom; #3;
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL to_ready got %b exp 0001", req_ready); end
    cycle_start();
    req_valid = '0; #3;
    checks++; if (uart_tx_start !== 1'b1) begin fails++; $display("FAIL to_start got %b exp 1", uart_tx_start); end
    for (int k = 1; k <= 16; k++) begin
      cycle_start(); #3;
      checks++;
      if (timeout_err !== 1'b0 || active !== 1'b1) begin
        fails++; $display("FAIL to_early k=%0d err=%b active=%b exp err 0 active 1", k, timeout_err, active);
      end
    end
    // 17 cycles after the start pulse; next search begins after requester 0
    cycle_start();
    req_valid = 4'b1111; err_clr = 1'b1; #3;
    checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_err got %b exp 1", timeout_err); end
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL to_active got %b exp 0", active); end
    checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL to_next_ready got %b exp 0010", req_ready); end
    cycle_start();
    req_valid = '0; err_clr = 1'b0; #3;
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_clr got %b exp 0", timeout_err); end
    checks++; if (grant_id !== 2'd1 || uart_tx_start !== 1'b1) begin
      fails++; $display("FAIL to_next_gid gid=%0d start=%b exp 1 1", grant_id, uart_tx_start);
    end
    // Second timeout with err_clr asserted in the firing cycle
    for (int k = 1; k <= 16; k++) begin
      cycle_start();
      err_clr = (k == 16); #3;
    end
    cycle_start();
    err_clr = 1'b0; #3;
    checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_set_prio got %b exp 1", timeout_err); end
    cycle_start();
    err_clr = 1'b1; #3;
    cycle_start();
    err_clr = 1'b0; #3;
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_clr2 got %b exp 0", timeout_err); end
  endtask

  task automatic test_busy_hold();
    do_reset();
    uart_tx_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle_start();
      req_valid = 4'b1111; #3;
      checks++;
      if (req_ready !== 4'b0) begin fails++; $display("FAIL busy_hold k=%0d got %b exp 0", k, req_ready); end
    end
    cycle_start();
    uart_tx_busy = 1'b0; #3;
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL busy_release got %b exp 0001", req_ready); end
    cycle_start();
    req_valid = '0; #3;
    checks++; if (grant_id !== 2'd0 || uart_tx_start !== 1'b1) begin
      fails++; $display("FAIL busy_grant gid=%0d start=%b exp 0 1", grant_id, uart_tx_start);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    auto_busy = 1'b1;
    cycle_start();
    req_valid = 4'b0100; req_data = $urandom; #3;
    cycle_start();
    req_valid = '0; #3;
    cycle_start(); #3;
    cycle_start(); #3;                   // now in WAIT_DONE
    checks++; if (active !== 1'b1) begin fails++; $display("FAIL mid_pre_active got %b exp 1", active); end
    rst_n = 1'b0;
    cycle_start();
    auto_busy = 1'b0; uart_tx_busy = 1'b0;
    req_valid = 4'b1010; #3;
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL mid_active got %b exp 0", active); end
    checks++; if (uart_tx_start !== 1'b0) begin fails++; $display("FAIL mid_start got %b exp 0", uart_tx_start); end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL mid_err got %b exp 0", timeout_err); end
    checks++; if (req_ready !== 4'b0) begin fails++; $display("FAIL mid_ready_rst got %b exp 0", req_ready); end
    cycle_start();
    rst_n = 1'b1; #3;
    checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL mid_ready got %b exp 0010", req_ready); end
    cycle_start();
    req_valid = '0; #3;
    checks++; if (grant_id !== 2'd1) begin fails++; $display("FAIL mid_gid got %0d exp 1", grant_id); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_busy_hold();
    test_reset_mid();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
